// File: rtl/mem_pkg.sv
// Shared definitions for the CPU/video memory arbiter: bus widths and the
// arbiter state encoding.
package mem_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_VADR = 2'd1,
        S_VDAT = 2'd2
    } state_t;

    // Countdown of CPU slots still owed before the next video steal.
    function automatic logic [7:0] gap_dec(input logic [7:0] cnt);
        return (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Steals cycles from the CPU for a read-only video port on one shared byte
// memory, hiding the stall from the CPU by replaying its last read data.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int CPU_GAP = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_out,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_in,
    output logic              cpu_ce,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_out,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_in
);

    localparam logic [7:0] GAP_LOAD = CPU_GAP[7:0];

    state_t            state;
    logic [7:0]        gap_cnt;
    logic [DATA_W-1:0] hold;
    logic              prev_cpu;
    logic              gap_ok;

    // The grant cycle is itself a CPU slot, so it counts as the last one owed.
    assign gap_ok = (gap_cnt <= 8'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_CPU;
            gap_cnt  <= 8'd0;
            hold     <= '0;
            prev_cpu <= 1'b1;
        end else if (ce) begin
            prev_cpu <= (state == S_CPU);
            if (prev_cpu)
                hold <= mem_in;
            case (state)
                S_CPU: begin
                    if (vid_req && gap_ok)
                        state <= S_VADR;
                    else
                        gap_cnt <= gap_dec(gap_cnt);
                end
                S_VADR: state <= S_VDAT;
                S_VDAT: begin
                    state   <= S_CPU;
                    gap_cnt <= GAP_LOAD;
                end
                default: state <= S_CPU;
            endcase
        end
    end

    always_comb begin
        cpu_ce      = 1'b0;
        mem_we      = 1'b0;
        vid_ack     = 1'b0;
        mem_address = cpu_address;
        case (state)
            S_CPU: begin
                cpu_ce = ce;
                mem_we = cpu_we & ce;
            end
            S_VADR: mem_address = vid_address;
            S_VDAT: vid_ack = ce;
            default: ;
        endcase
        // Reset also kills any steal in flight: no ack, no write, CPU held.
        if (!reset_n) begin
            cpu_ce  = 1'b0;
            mem_we  = 1'b0;
            vid_ack = 1'b0;
        end
    end

    // While stalled the CPU keeps seeing the byte captured from its last slot.
    assign cpu_in   = prev_cpu ? mem_in : hold;
    assign vid_data = mem_in;
    assign mem_out  = cpu_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural byte memory, video-data scoreboard and
// directed CPU/steal sequences.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int GAP = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              ce;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_out;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_in;
    logic              cpu_ce;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_address;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_data;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_out;
    logic              mem_we;
    logic [DATA_W-1:0] mem_in;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int wr300    = 0;

    mem_arbiter #(.CPU_GAP(GAP)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
        .cpu_in(cpu_in), .cpu_ce(cpu_ce),
        .vid_req(vid_req), .vid_address(vid_address),
        .vid_ack(vid_ack), .vid_data(vid_data),
        .mem_address(mem_address), .mem_out(mem_out), .mem_we(mem_we),
        .mem_in(mem_in)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_address] <= mem_out;
        mem_in <= mem[mem_address];
        if (mem_we && mem_address == 20'h00300) wr300 <= wr300 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every vid_ack must match the oldest outstanding request.
    always @(negedge clock) begin
        if (vid_ack) begin
            if (exp_q.size() == 0) chk("vid_ack_unexpected", 32'd1, 32'd0);
            else                   chk("vid_data", vid_data, exp_q.pop_front());
        end
        if (mem_we) chk("we_outside_cpu", cpu_ce, 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_ack;
        int n_ce;
        int last;
        reset_n = 0; ce = 1; vid_req = 1; cpu_we = 1;
        cpu_address = '0; cpu_out = '0; vid_address = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_cpu_ce", cpu_ce, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_vid_ack", vid_ack, 0);
            next_cyc();
        end
        reset_n = 1; vid_req = 0; cpu_we = 0; cpu_address = 20'h00200;
        @(negedge clock);
        chk("rel_cpu_ce", cpu_ce, 1);
        chk("rel_mem_addr", mem_address, 20'h00200);
        next_cyc();

        // CPU write then read
        cpu_address = 20'h12345; cpu_out = 8'hA5; cpu_we = 1;
        @(negedge clock);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_out", mem_out, 8'hA5);
        chk("wr_mem_addr", mem_address, 20'h12345);
        next_cyc();
        cpu_we = 0;
        @(negedge clock);
        chk("rd_mem_we", mem_we, 0);
        next_cyc();
        cpu_address = 20'hB8000; cpu_out = 8'h41; cpu_we = 1;
        @(negedge clock);
        chk("rd_cpu_in", cpu_in, 8'hA5);
        next_cyc();
        cpu_address = 20'h00100; cpu_out = 8'h11;
        @(negedge clock);
        next_cyc();

        // Video read
        cpu_we = 0; cpu_address = 20'h00200;
        vid_req = 1; vid_address = 20'hB8000; exp_q.push_back(8'h41);
        @(negedge clock);
        chk("grant_cpu_ce", cpu_ce, 1);
        chk("grant_mem_addr", mem_address, 20'h00200);
        next_cyc();
        @(negedge clock);
        chk("vadr_mem_addr", mem_address, 20'hB8000);
        chk("vadr_cpu_ce", cpu_ce, 0);
        chk("vadr_mem_we", mem_we, 0);
        chk("vadr_vid_ack", vid_ack, 0);
        next_cyc();
        @(negedge clock);
        chk("vdat_vid_ack", vid_ack, 1);
        chk("vdat_cpu_ce", cpu_ce, 0);
        next_cyc();
        vid_req = 0;
        @(negedge clock);
        chk("resume_cpu_ce", cpu_ce, 1);
        chk("resume_vid_ack", vid_ack, 0);
        next_cyc();
        for (int i = 0; i < 3; i++) next_cyc();

        // Transparency across a steal with a write held during the stall
        cpu_address = 20'h00100; vid_req = 1; exp_q.push_back(8'h41);
        @(negedge clock);
        chk("tr_grant_cpu_ce", cpu_ce, 1);
        next_cyc();
        cpu_we = 1; cpu_out = 8'h77; cpu_address = 20'h00300;
        @(negedge clock);
        chk("tr_vadr_cpu_in", cpu_in, 8'h11);
        chk("tr_vadr_mem_we", mem_we, 0);
        chk("tr_vadr_cpu_ce", cpu_ce, 0);
        next_cyc();
        @(negedge clock);
        chk("tr_vdat_cpu_in", cpu_in, 8'h11);
        chk("tr_vdat_mem_we", mem_we, 0);
        chk("tr_vdat_vid_ack", vid_ack, 1);
        next_cyc();
        vid_req = 0;
        @(negedge clock);
        chk("tr_resume_cpu_in", cpu_in, 8'h11);
        chk("tr_resume_mem_we", mem_we, 1);
        next_cyc();
        cpu_we = 0;
        @(negedge clock);
        chk("tr_rd_mem_we", mem_we, 0);
        next_cyc();
        @(negedge clock);
        chk("tr_rd_cpu_in", cpu_in, 8'h77);
        chk("tr_write_count", wr300, 1);
        next_cyc();

        // Fairness with vid_req held high
        n_ack = 0; n_ce = 0; last = -1;
        cpu_address = 20'h00200;
        for (int i = 0; i < 20; i++) begin
            vid_req = (i < 18);
            if (i == 0) exp_q.push_back(8'h41);
            @(negedge clock);
            if (cpu_ce) n_ce++;
            if (vid_ack) begin
                n_ack++;
                if (last >= 0) chk("fair_ack_period", i - last, 5);
                last = i;
                if (i < 17) exp_q.push_back(8'h41);
            end
            next_cyc();
        end
        chk("fair_ack_count", n_ack, 4);
        chk("fair_cpu_ce_count", n_ce, 12);

        // ce=0 freeze inside S_VADR, then reset inside S_VDAT
        vid_req = 1; vid_address = 20'hB8000;
        @(negedge clock);
        chk("fz_grant_cpu_ce", cpu_ce, 1);
        next_cyc();
        ce = 0; cpu_we = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("fz_mem_addr", mem_address, 20'hB8000);
            chk("fz_mem_we", mem_we, 0);
            chk("fz_cpu_ce", cpu_ce, 0);
            chk("fz_vid_ack", vid_ack, 0);
            next_cyc();
        end
        ce = 1; cpu_we = 0; cpu_address = 20'h00555;
        @(negedge clock);
        chk("fz_still_vadr", mem_address, 20'hB8000);
        next_cyc();
        reset_n = 0;
        @(negedge clock);
        chk("rs_vdat_addr", mem_address, 20'h00555);
        chk("rs_vid_ack", vid_ack, 0);
        chk("rs_cpu_ce", cpu_ce, 0);
        next_cyc();
        reset_n = 1; vid_req = 0;
        @(negedge clock);
        chk("rs_after_cpu_ce", cpu_ce, 1);
        chk("rs_after_vid_ack", vid_ack, 0);
        next_cyc();
        for (int i = 0; i < 3; i++) next_cyc();
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
